alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, pipelined successor of the 4-bit registered ALU. Width is generic.
//  Opcode set is extended to 3 bits. Adds valid/ready flow control on both sides,
//  an optional saturating mode, status flags and a completed-operation counter.
//  Sits between the operand sequencer (upstream) and the result writeback (downstream).
// PARAMETERS
//  WIDTH     4   operand width; a/b are 2's complement; result c is WIDTH+1 bits
//  SATURATE  0   0: ADD/SUB give the full WIDTH+1 result; 1: clamp ADD/SUB to WIDTH-bit signed range
//  CNT_W     16  width of op_count
// PORTS
//  clk        in   1          clock, all logic on posedge
//  reset      in   1          synchronous, active-low reset
//  in_valid   in   1          operands/opcode valid
//  in_ready   out  1          block can accept; transfer when in_valid && in_ready
//  opcode     in   3          operation, see table
//  a          in   WIDTH      operand A, signed
//  b          in   WIDTH      operand B, signed
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts; transfer when out_valid && out_ready
//  c          out  WIDTH+1    result, signed
//  flag_zero  out  1          c == 0
//  flag_neg   out  1          c[WIDTH]
//  flag_ovf   out  1          ADD/SUB true result outside WIDTH-bit signed range
//  op_count   out  CNT_W      count of output handshakes, wraps to 0
// BEHAVIOUR
//  Opcodes (sign-extend a/b to WIDTH+1 first):
//   000 ADD = a+b
//   001 SUB = a-b
//   010 NOT_A = ~a
//   011 REDOR_B = {0..,|b}
//   100 AND = a&b
//   101 OR = a|b
//   110 XOR = a^b
//   111 reserved: c=0, flags follow c, still counted
//  SATURATE=1, ADD/SUB with ovf=1:
//   c = +(2^(WIDTH-1)-1) if the true result is positive, else -2^(WIDTH-1)
//   flag_ovf stays 1
//  Logic ops always give flag_ovf = 0.
//  Pipeline: S1 registers the inputs; S2 computes and registers c and the flags.
//   Latency: out_valid rises 2 clocks after the input handshake.
//   Throughput: 1 op per clock when out_ready = 1.
//  Flow control:
//   s2_adv   = !s2_valid || out_ready
//   in_ready = !s1_valid || s2_adv
//   in_ready is registered-free and depends on out_ready combinationally.
//  While out_valid && !out_ready: c, flags and out_valid hold stable.
//   Capacity under stall is 2 ops; in_ready drops once both stages are full.
//  Simultaneous output handshake and new input: both happen in the same clock.
//   No bubble, no loss, no duplication; results leave in input order.
//  op_count increments on each output handshake and wraps from 2^CNT_W-1 to 0.
//  Reset (reset==0 at posedge): S1/S2 valids flushed.
//   out_valid, c, flags and op_count all go to 0.
//   in_ready = 0 while reset is held, and 1 on the first clock after release.
//   Ops in flight when reset is applied are discarded and never presented.
//  Inputs are ignored while in_ready = 0.
// STRUCTURE
//  alu_pkg: typedef enum logic [2:0] alu_op_e {ADD,SUB,NOT_A,REDOR_B,AND,OR,XOR,RSVD}.
//  alu_core: one combinational sub-module.
//   Params: WIDTH, SATURATE. Inputs: op, a, b. Outputs: c, zero, neg, ovf.
//   Instantiated once, between S1 and S2.
//  alu_pipe holds only the stage registers, handshake logic and the counter.
// TESTING (WIDTH=4)
//  SAT=0, ADD a=-8 b=-8 -> c=-16 (5'b10000), ovf=1, neg=1, out_valid exactly 2 clocks after accept
//  SAT=1: SUB a=7 b=-8 -> c=7, ovf=1; ADD a=-8 b=-1 -> c=-8, ovf=1; ADD 3+2 -> c=5, ovf=0
//  NOT_A a=0000 -> 5'b11111; REDOR_B b=0000 -> c=0, zero=1; b=0001,0010,0100,1000 -> c=1 each
//  Stall: out_ready=0, offer 4 ops -> 2 accepted, then in_ready=0 and c held;
//   release -> 4 results in order, op_count=4
//  Stream: 8 ops with out_ready=1 -> 8 results on 8 consecutive clocks, op_count=8
//  Reset: reset=0 with 2 ops in flight -> next clk out_valid=0, c=0, op_count=0,
//   in_ready=0; after release in_ready=1 and no stale result appears

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode encoding shared by the pipelined ALU and its datapath.
// Every 3-bit code is named; RSVD yields zero but still counts as an op.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD     = 3'd0,
    SUB     = 3'd1,
    NOT_A   = 3'd2,
    REDOR_B = 3'd3,
    AND     = 3'd4,
    OR      = 3'd5,
    XOR     = 3'd6,
    RSVD    = 3'd7
  } alu_op_e;

  localparam int unsigned OP_W = 3;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational datapath between S1 and S2 of alu_pipe.
// Operands are sign-extended so ADD/SUB results never wrap.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   c,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  logic [WIDTH:0] w_ae;
  logic [WIDTH:0] w_be;
  logic [WIDTH:0] w_raw;
  logic [WIDTH:0] w_max;
  logic [WIDTH:0] w_min;
  logic           w_arith;

  assign w_ae  = {a[WIDTH-1], a};
  assign w_be  = {b[WIDTH-1], b};
  assign w_max = {2'b00, {(WIDTH-1){1'b1}}};
  assign w_min = {2'b11, {(WIDTH-1){1'b0}}};

  always_comb begin
    w_raw   = '0;
    w_arith = 1'b0;
    unique case (op)
      ADD: begin
        w_raw   = w_ae + w_be;
        w_arith = 1'b1;
      end
      SUB: begin
        w_raw   = w_ae - w_be;
        w_arith = 1'b1;
      end
      NOT_A:   w_raw = ~w_ae;
      REDOR_B: w_raw = {{WIDTH{1'b0}}, |b};
      AND:     w_raw = w_ae & w_be;
      OR:      w_raw = w_ae | w_be;
      XOR:     w_raw = w_ae ^ w_be;
      RSVD:    w_raw = '0;
    endcase
  end

  // top two bits disagree: the exact sum does not fit in WIDTH signed bits
  assign ovf = w_arith & (w_raw[WIDTH] ^ w_raw[WIDTH-1]);

  always_comb begin
    c = w_raw;
    if (SATURATE && ovf) begin
      c = w_raw[WIDTH] ? w_min : w_max;
    end
  end

  assign zero = (c == '0);
  assign neg  = c[WIDTH];

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU (S1 operands, S2 result + flags).
// Holds two ops under back-pressure; in_ready sees out_ready combinationally.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   c,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             flag_ovf,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             r_s1_valid;
  alu_op_e          r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  logic             r_s2_valid;
  logic [WIDTH:0]   r_c;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;

  logic             w_s2_adv;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic [WIDTH:0]   w_c;
  logic             w_zero;
  logic             w_neg;
  logic             w_ovf;

  assign w_s2_adv   = !r_s2_valid || out_ready;
  assign w_in_ready = reset && (!r_s1_valid || w_s2_adv);
  assign w_in_fire  = in_valid && w_in_ready;
  assign w_out_fire = r_s2_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
    end else if (w_in_ready) begin
      r_s1_valid <= in_valid;
    end
  end

  // operand registers need no reset: they only matter behind r_s1_valid
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_s1_op <= alu_op_e'(opcode);
      r_s1_a  <= a;
      r_s1_b  <= b;
    end
  end

  alu_core #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_core (
    .op  (r_s1_op),
    .a   (r_s1_a),
    .b   (r_s1_b),
    .c   (w_c),
    .zero(w_zero),
    .neg (w_neg),
    .ovf (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_c        <= '0;
      r_zero     <= 1'b0;
      r_neg      <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_c    <= w_c;
        r_zero <= w_zero;
        r_neg  <= w_neg;
        r_ovf  <= w_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
    end else if (w_out_fire) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_s2_valid;
  assign c         = r_c;
  assign flag_zero = r_zero;
  assign flag_neg  = r_neg;
  assign flag_ovf  = r_ovf;
  assign op_count  = r_count;

endmodule
